// File: rtl/unbin_upscale.sv
// unbin_upscale
//   Nearest-neighbour upscaler that undoes the KERNEL_SIZE x KERNEL_SIZE mask
//   binning. Binned mask pixels are stored one row at a time in a two-bank
//   ping-pong line buffer. Display requests (hcount/vcount) are mapped back
//   to the binned grid, so each binned pixel is replayed as a
//   KERNEL_SIZE x KERNEL_SIZE block.
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   bin_hcount_in   binned column of the incoming mask pixel
//   bin_vcount_in   binned row of the incoming mask pixel
//   bin_pixel_in    binned mask pixel
//   bin_valid_in    binned pixel valid
//   hcount_in       requested display column
//   vcount_in       requested display row
//   read_valid_in   display request valid (active area)
//   pixel_data_out  upscaled mask pixel (0 when the row is not buffered)
//   hcount_out      hcount_in delayed to line up with pixel_data_out
//   vcount_out      vcount_in delayed to line up with pixel_data_out
//   data_valid_out  read_valid_in delayed to line up with pixel_data_out
//   underrun_out    sticky until reset: a request hit an unbuffered row
module unbin_upscale #(
  parameter int HRES        = 1280,
  parameter int VRES        = 720,
  parameter int KERNEL_SIZE = 4,
  localparam int HWIDTH     = $clog2(HRES),
  localparam int VWIDTH     = $clog2(VRES),
  localparam int KW         = $clog2(KERNEL_SIZE)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [HWIDTH-KW-1:0] bin_hcount_in,
  input  logic [VWIDTH-KW-1:0] bin_vcount_in,
  input  logic                 bin_pixel_in,
  input  logic                 bin_valid_in,
  input  logic [HWIDTH-1:0]    hcount_in,
  input  logic [VWIDTH-1:0]    vcount_in,
  input  logic                 read_valid_in,
  output logic                 pixel_data_out,
  output logic [HWIDTH-1:0]    hcount_out,
  output logic [VWIDTH-1:0]    vcount_out,
  output logic                 data_valid_out,
  output logic                 underrun_out
);

  localparam int BW  = HRES / KERNEL_SIZE;
  localparam int BHW = HWIDTH - KW;
  localparam int BVW = VWIDTH - KW;
  localparam int AW  = (BW > 1) ? $clog2(BW) : 1;

  // Two line banks; the binned row's LSB picks the bank so consecutive rows
  // alternate and row R+1 can fill while row R is being replayed.
  logic              bank_mem [2][BW];
  logic [1:0]        bank_valid;
  logic [BVW-1:0]    bank_tag [2];

  // Write side. The compare is widened by one bit because BW itself may not
  // fit in the binned column width when HRES/KERNEL_SIZE is a power of two.
  logic              wr_en;
  logic              wr_bank;
  logic [AW-1:0]     wr_addr;

  assign wr_en   = bin_valid_in && ({1'b0, bin_hcount_in} < (BHW+1)'(BW));
  assign wr_bank = bin_vcount_in[0];
  assign wr_addr = bin_hcount_in[AW-1:0];

  // Read side: the display coordinate divided by the kernel size is the
  // binned coordinate, which gives the replication in both directions.
  logic [BVW-1:0]    rd_row;
  logic              rd_bank;
  logic [AW-1:0]     rd_addr;
  logic              rd_hit;

  assign rd_row  = vcount_in[VWIDTH-1:KW];
  assign rd_bank = rd_row[0];
  assign rd_addr = hcount_in[AW+KW-1:KW];
  // Uses the registered bank state, i.e. before this cycle's write lands.
  assign rd_hit  = bank_valid[rd_bank] && (bank_tag[rd_bank] == rd_row);

  // A row becomes readable only once its last column is written; starting a
  // new row in a bank invalidates whatever that bank held.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bank_valid  <= '0;
      bank_tag[0] <= '0;
      bank_tag[1] <= '0;
    end else if (wr_en) begin
      if (bin_hcount_in == '0) begin
        bank_valid[wr_bank] <= 1'b0;
      end
      if (bin_hcount_in == BHW'(BW-1)) begin
        bank_valid[wr_bank] <= 1'b1;
        bank_tag[wr_bank]   <= bin_vcount_in;
      end
    end
  end

  logic              ram_q_p1;
  logic              vld_p1;
  logic              hit_p1;
  logic [HWIDTH-1:0] hcount_p1;
  logic [VWIDTH-1:0] vcount_p1;

  // Stage p0 -> p1: RAM port A write, port B read (read-first) into the
  // array output register.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      bank_mem[wr_bank][wr_addr] <= bin_pixel_in;
    end
    ram_q_p1 <= bank_mem[rd_bank][rd_addr];
  end

  // Stage p0 -> p1: request control and coordinates travel with the read.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_p1    <= 1'b0;
      hit_p1    <= 1'b0;
      hcount_p1 <= '0;
      vcount_p1 <= '0;
    end else begin
      vld_p1    <= read_valid_in;
      hit_p1    <= read_valid_in && rd_hit;
      hcount_p1 <= hcount_in;
      vcount_p1 <= vcount_in;
    end
  end

  // Stage p1 -> p2: RAM pipeline register doubles as the output register,
  // gated by the hit decision.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pixel_data_out <= 1'b0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      data_valid_out <= 1'b0;
      underrun_out   <= 1'b0;
    end else begin
      pixel_data_out <= vld_p1 && hit_p1 && ram_q_p1;
      hcount_out     <= hcount_p1;
      vcount_out     <= vcount_p1;
      data_valid_out <= vld_p1;
      if (vld_p1 && !hit_p1) begin
        underrun_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_unbin_upscale.sv
module tb_unbin_upscale;

  localparam int HRES = 80;
  localparam int VRES = 48;
  localparam int K    = 4;
  localparam int HW   = $clog2(HRES);
  localparam int VW   = $clog2(VRES);
  localparam int KW   = $clog2(K);
  localparam int BW   = HRES / K;
  localparam int BHW  = HW - KW;
  localparam int BVW  = VW - KW;

  logic           clk = 1'b0;
  logic           rst_in;
  logic [BHW-1:0] bin_hcount_in;
  logic [BVW-1:0] bin_vcount_in;
  logic           bin_pixel_in;
  logic           bin_valid_in;
  logic [HW-1:0]  hcount_in;
  logic [VW-1:0]  vcount_in;
  logic           read_valid_in;
  logic           pixel_data_out;
  logic [HW-1:0]  hcount_out;
  logic [VW-1:0]  vcount_out;
  logic           data_valid_out;
  logic           underrun_out;

  unbin_upscale #(.HRES(HRES), .VRES(VRES), .KERNEL_SIZE(K)) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .bin_hcount_in (bin_hcount_in),
    .bin_vcount_in (bin_vcount_in),
    .bin_pixel_in  (bin_pixel_in),
    .bin_valid_in  (bin_valid_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .read_valid_in (read_valid_in),
    .pixel_data_out(pixel_data_out),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out),
    .data_valid_out(data_valid_out),
    .underrun_out  (underrun_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic          pix;
    logic          hit;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
  } exp_t;

  exp_t           sb[$];
  logic           m_mem [2][BW];
  logic [1:0]     m_valid;
  int             m_tag [2];
  logic           exp_under;
  int             edge_cnt = 0;
  logic           rst_edge;
  logic           done = 1'b0;
  int             n_checks = 0;
  int             n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", tag, got, want, edge_cnt);
    end
  endtask

  // Reference model and scoreboard: predictions are made at the sampling
  // edge and compared one edge later, half a cycle after the output edge.
  always begin
    exp_t e;
    int   r;
    int   a;
    int   b;
    logic expv;
    @(posedge clk);
    edge_cnt++;
    rst_edge = rst_in;
    if (rst_in) begin
      sb.delete();
      m_valid = 2'b00;
      m_tag[0] = 0;
      m_tag[1] = 0;
    end else if (read_valid_in) begin
      r = int'(vcount_in) / K;
      a = int'(hcount_in) / K;
      b = r % 2;
      e.hit = m_valid[b] && (m_tag[b] == r);
      e.pix = e.hit ? m_mem[b][a] : 1'b0;
      e.h   = hcount_in;
      e.v   = vcount_in;
      e.due = edge_cnt + 1;
      sb.push_back(e);
    end
    if (bin_valid_in && int'(bin_hcount_in) < BW) begin
      b = int'(bin_vcount_in) % 2;
      m_mem[b][int'(bin_hcount_in)] = bin_pixel_in;
      if (!rst_in) begin
        if (int'(bin_hcount_in) == 0) m_valid[b] = 1'b0;
        if (int'(bin_hcount_in) == BW-1) begin
          m_valid[b] = 1'b1;
          m_tag[b]   = int'(bin_vcount_in);
        end
      end
    end

    @(negedge clk);
    if (rst_edge) begin
      exp_under = 1'b0;
      chk("rst_pixel", pixel_data_out, 0);
      chk("rst_hcount", hcount_out, 0);
      chk("rst_vcount", vcount_out, 0);
    end
    expv = (sb.size() > 0) && (sb[0].due == edge_cnt);
    chk("data_valid", data_valid_out, expv);
    if (expv) begin
      e = sb.pop_front();
      chk("pixel", pixel_data_out, e.pix);
      chk("hcount", hcount_out, e.h);
      chk("vcount", vcount_out, e.v);
      if (!e.hit) exp_under = 1'b1;
    end
    chk("underrun", underrun_out, exp_under);
    if (done) begin
      chk("drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
    end
  end

  task automatic tick(input logic r, input logic bv, input int bvc, input int bhc,
                      input logic bp, input logic rv, input int vc, input int hc);
    rst_in        = r;
    bin_valid_in  = bv;
    bin_vcount_in = BVW'(bvc);
    bin_hcount_in = BHW'(bhc);
    bin_pixel_in  = bp;
    read_valid_in = rv;
    vcount_in     = VW'(vc);
    hcount_in     = HW'(hc);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
  endtask

  // mode 0: all zeros, 1: all ones, 2: 1010... starting with 1 at column 0
  task automatic wr_row(input int row, input int mode);
    for (int c = 0; c < BW; c++)
      tick(0, 1, row, c, (mode == 1) ? 1'b1 : (mode == 2) ? ((c % 2) == 0) : 1'b0, 0, 0, 0);
  endtask

  task automatic rd(input int v, input int h);
    tick(0, 0, 0, 0, 0, 1, v, h);
  endtask

  initial begin
    int rr;
    int cc;
    rst_in = 1'b1; bin_valid_in = 1'b0; bin_vcount_in = '0; bin_hcount_in = '0;
    bin_pixel_in = 1'b0; read_valid_in = 1'b0; vcount_in = '0; hcount_in = '0;
    @(negedge clk);
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Miss straight after reset
    rd(4, 0);
    idle(4);

    // Basic replay of a 1010 row over 4 lines x 16 columns
    do_reset();
    wr_row(0, 2);
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 16; h++) rd(v, h);
    idle(3);

    // Ping-pong: row 1 streams in while row 0 is replayed
    do_reset();
    wr_row(0, 1);
    for (int i = 0; i < 64; i++)
      tick(0, (i < BW), 1, i, 1'b0, 1, i / 16, i % 16);
    for (int h = 0; h < 4; h++) rd(4, h * 4);
    // Partial row 3 must miss, including on the cycle its last column lands
    for (int c = 0; c < BW; c++) tick(0, 1, 3, c, 1'b1, 1, 12, 0);
    rd(12, 0);
    rd(13, 5);
    idle(3);

    // Overwrite: starting row 2 evicts row 0 from bank 0
    do_reset();
    wr_row(0, 1);
    tick(0, 1, 2, 0, 1'b0, 0, 0, 0);
    rd(0, 0);
    idle(3);

    // Out-of-range columns are ignored
    do_reset();
    wr_row(0, 1);
    tick(0, 1, 0, BW, 1'b0, 0, 0, 0);
    tick(0, 1, 2, BW, 1'b0, 0, 0, 0);
    tick(0, 1, 0, (1 << BHW) - 1, 1'b0, 0, 0, 0);
    for (int h = 0; h < HRES; h += 7) rd(2, h);
    idle(3);

    // Reset in the middle of a read burst
    do_reset();
    wr_row(0, 2);
    for (int h = 0; h < 16; h++) begin
      if (h == 8) tick(1, 0, 0, 0, 0, 1, 0, h);
      else rd(1, h);
    end
    idle(3);

    // Free-running mix: rows written in order with gaps, random requests
    do_reset();
    rr = 0;
    cc = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        tick(0, 1, rr, $urandom_range(BW, (1 << BHW) - 1), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, VRES - 1), $urandom_range(0, HRES - 1));
      end else if ($urandom_range(0, 3) != 0) begin
        tick(0, 1, rr, cc, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, VRES - 1), $urandom_range(0, HRES - 1));
        cc++;
        if (cc == BW) begin
          cc = 0;
          rr = (rr + 1) % (VRES / K);
        end
      end else begin
        tick(0, 0, 0, 0, 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, VRES - 1), $urandom_range(0, HRES - 1));
      end
    end
    idle(4);
    done = 1'b1;
    repeat (20) @(negedge clk);
    $display("FAIL timeout: summary not reached");
    $fatal(1);
  end

endmodule
